// File: rtl/rr_arbiter16_pkg.sv
// Shared constants for the 16-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arbiter16_pkg;

  // Arbiter state encodings
  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;

  // Requester count and matching index width
  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

endpackage

// File: rtl/rr_arbiter16_decoder4x16.sv
// 4-to-16 one-hot decoder with enable; all zeros when disabled.
// Latency: purely combinational.
// Backpressure: none.
module decoder4x16 (
  input  logic [3:0]  in,
  input  logic        en,
  output logic [15:0] dout
);

  // One-hot decode of the index, forced to zero when not enabled
  always_comb begin
    dout = 16'h0000;
    if (en) begin
      dout = 16'h0001 << in;
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: one holder of a 16-way resource, held until done/drop (or hold limit).
// Latency: 1 cycle req->gnt and done->release; handover is back-to-back with no idle gap.
// Backpressure: losing requesters simply wait; no preemption. Hold limit built with ARB_TIMEOUT_EN.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [IDX_W-1:0] HoldLast = IDX_W'(HOLD_MAX - 1);

  logic             state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic [IDX_W-1:0]   ptr_after;
  logic [NUM_REQ-1:0] req_masked;
  logic [IDX_W:0]     pick_idle;
  logic [IDX_W:0]     pick_rel;
  logic               holder_drop;
  logic               limit_hit;
  logic               release_now;

`ifdef ARB_TIMEOUT_EN
  logic [IDX_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`else
  // HOLD_MAX only matters when the hold limit is compiled in
  logic             hold_unused;
  assign hold_unused = ^HoldLast;
`endif

  // Rotating priority search: first set bit of r starting at p, wrapping 15->0.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] r,
                                          input logic [IDX_W-1:0]   p);
    logic             found;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    sel   = p;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = p + IDX_W'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  // Candidate winners for the idle case and for a release (old holder masked out)
  always_comb begin
    ptr_after   = gnt_idx_q + IDX_W'(1);
    req_masked  = req & ~(NUM_REQ'(1) << gnt_idx_q);
    pick_idle   = pick(req, ptr_q);
    pick_rel    = pick(req_masked, ptr_after);
    holder_drop = !req[gnt_idx_q];
`ifdef ARB_TIMEOUT_EN
    limit_hit   = (hold_cnt_q == HoldLast);
`else
    limit_hit   = 1'b0;
`endif
    release_now = done | holder_drop | limit_hit;
  end

  // Next-state logic for state, pointer, holder index and hold counter
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    if (state_q == ARB_IDLE) begin
      if (pick_idle[IDX_W]) begin
        state_d   = ARB_GRANT;
        gnt_idx_d = pick_idle[IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = '0;
`endif
      end
    end else begin
      if (release_now) begin
        ptr_d = ptr_after;
`ifdef ARB_TIMEOUT_EN
        // Flag only revocations caused purely by the hold limit
        timeout_d  = !done && !holder_drop;
        hold_cnt_d = '0;
`endif
        if (pick_rel[IDX_W]) begin
          gnt_idx_d = pick_rel[IDX_W-1:0];
        end else begin
          state_d = ARB_IDLE;
        end
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + IDX_W'(1);
        end
`endif
      end
    end
  end

  // Core arbiter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and registered timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == ARB_GRANT);

  decoder4x16 u_dec (
    .in   (gnt_idx_q),
    .en   (gnt_valid),
    .dout (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed self-checking bench for rr_arbiter16 (HOLD_MAX=4).
// Latency: checks 1-cycle grant/release and back-to-back handover.
// Backpressure: n/a.
module tb_rr_arbiter16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int tests_run;
  int tests_failed;

  rr_arbiter16 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || gnt_idx !== 4'd0 || timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle: gnt=%h valid=%b idx=%0d to=%b, expected 0000/0/0/0",
                 gnt, gnt_valid, gnt_idx, timeout);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0010;
    step();
    tests_run++;
    if (gnt !== 16'h0010 || gnt_idx !== 4'd4 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, expected 0010/4/1", gnt, gnt_idx, gnt_valid);
    end
    done = 1'b1;
    step();
    tests_run++;
    if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: gnt=%h valid=%b, expected 0000/0", gnt, gnt_valid);
    end
    // ptr is now 5: with bits 0 and 4 requesting, the scan from 5 reaches 0 first
    done = 1'b0;
    req  = 16'h0011;
    step();
    tests_run++;
    if (gnt_idx !== 4'd0 || gnt !== 16'h0001) begin
      tests_failed++;
      $display("FAIL single_ptr5: idx=%0d gnt=%h, expected 0/0001", gnt_idx, gnt);
    end
    req = 16'h0000;
    step();
  endtask

  task automatic test_done_idle();
    do_reset();
    done = 1'b1;
    step();
    step();
    tests_run++;
    if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_idle: gnt=%h valid=%b, expected 0000/0", gnt, gnt_valid);
    end
    done = 1'b0;
    req  = 16'h0100;
    step();
    tests_run++;
    if (gnt_idx !== 4'd8 || gnt !== 16'h0100) begin
      tests_failed++;
      $display("FAIL done_idle_grant: idx=%0d gnt=%h, expected 8/0100", gnt_idx, gnt);
    end
    req = 16'h0000;
    step();
  endtask

  task automatic test_rotation();
    logic [15:0] exp_gnt;
    logic [3:0]  exp_idx;
    do_reset();
    req = 16'hFFFF;
    step();
    tests_run++;
    if (gnt_idx !== 4'd0 || gnt !== 16'h0001) begin
      tests_failed++;
      $display("FAIL rotation_first: idx=%0d gnt=%h, expected 0/0001", gnt_idx, gnt);
    end
    done = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_idx = 4'(k % 16);
      exp_gnt = 16'h0001 << exp_idx;
      tests_run++;
      if (gnt_idx !== exp_idx || gnt !== exp_gnt || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL rotation_step%0d: idx=%0d gnt=%h valid=%b, expected %0d/%h/1",
                 k, gnt_idx, gnt, gnt_valid, exp_idx, exp_gnt);
      end
    end
    done = 1'b0;
    req  = 16'h0000;
    step();
  endtask

  task automatic test_wrap_mask();
    do_reset();
    // Grant 13 then release with nobody waiting: ptr becomes 14
    req = 16'h2000;
    step();
    req  = 16'h0000;
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 16'h4001;
    step();
    tests_run++;
    if (gnt_idx !== 4'd14 || gnt !== 16'h4000) begin
      tests_failed++;
      $display("FAIL wrap_grant14: idx=%0d gnt=%h, expected 14/4000", gnt_idx, gnt);
    end
    done = 1'b1;
    step();
    tests_run++;
    if (gnt_idx !== 4'd0 || gnt !== 16'h0001 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_mask: idx=%0d gnt=%h valid=%b, expected 0/0001/1", gnt_idx, gnt, gnt_valid);
    end
    done = 1'b0;
    req  = 16'h0000;
    step();
  endtask

  task automatic test_drop();
    do_reset();
    req = 16'h0008;
    step();
    tests_run++;
    if (gnt_idx !== 4'd3) begin
      tests_failed++;
      $display("FAIL drop_hold3: idx=%0d, expected 3", gnt_idx);
    end
    req = 16'h0080;
    step();
    tests_run++;
    if (gnt_idx !== 4'd7 || gnt !== 16'h0080 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_handover: idx=%0d gnt=%h valid=%b, expected 7/0080/1", gnt_idx, gnt, gnt_valid);
    end
    // Newcomer must wait while 7 holds
    req = 16'h0081;
    step();
    tests_run++;
    if (gnt_idx !== 4'd7 || gnt !== 16'h0080) begin
      tests_failed++;
      $display("FAIL drop_no_preempt: idx=%0d gnt=%h, expected 7/0080", gnt_idx, gnt);
    end
    req = 16'h0000;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    // Move ptr to 13, then grant 7 (scan 13,14,15,0..7)
    req = 16'h1000;
    step();
    req  = 16'h0000;
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 16'h0080;
    step();
    tests_run++;
    if (gnt_idx !== 4'd7 || gnt !== 16'h0080) begin
      tests_failed++;
      $display("FAIL arst_pre: idx=%0d gnt=%h, expected 7/0080", gnt_idx, gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_async: gnt=%h valid=%b, expected 0000/0", gnt, gnt_valid);
    end
    step();
    rst = 1'b0;
    // From ptr 0 bit 7 wins; a stale ptr of 13 would pick 14
    req = 16'h4080;
    step();
    tests_run++;
    if (gnt_idx !== 4'd7) begin
      tests_failed++;
      $display("FAIL arst_ptr0: idx=%0d, expected 7", gnt_idx);
    end
    req = 16'h0000;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0003;
    step();
    tests_run++;
    if (gnt_idx !== 4'd0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_first: idx=%0d to=%b, expected 0/0", gnt_idx, timeout);
    end
    for (int c = 1; c < 4; c++) begin
      step();
      tests_run++;
      if (gnt_idx !== 4'd0 || timeout !== 1'b0 || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_hold%0d: idx=%0d to=%b valid=%b, expected 0/0/1",
                 c, gnt_idx, timeout, gnt_valid);
      end
    end
    step();
`ifdef ARB_TIMEOUT_EN
    tests_run++;
    if (gnt_idx !== 4'd1 || timeout !== 1'b1 || gnt !== 16'h0002) begin
      tests_failed++;
      $display("FAIL timeout_fire: idx=%0d to=%b gnt=%h, expected 1/1/0002", gnt_idx, timeout, gnt);
    end
    step();
    tests_run++;
    if (gnt_idx !== 4'd1 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: idx=%0d to=%b, expected 1/0", gnt_idx, timeout);
    end
`else
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (gnt_idx !== 4'd0 || timeout !== 1'b0 || gnt !== 16'h0001) begin
        tests_failed++;
        $display("FAIL no_timeout_hold%0d: idx=%0d to=%b gnt=%h, expected 0/0/0001",
                 c, gnt_idx, timeout, gnt);
      end
      step();
    end
`endif
    req = 16'h0000;
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    test_reset();
    test_single();
    test_done_idle();
    test_rotation();
    test_wrap_mask();
    test_drop();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
